// File: rtl/serial_chunk_adder.sv
// Purpose: WIDTH-bit add/subtract done CHUNK bits per cycle, LSB slice first, with a registered carry between slices.
// Latency: out_valid rises N = WIDTH/CHUNK cycles after the accepting edge; one result per N+2 cycles back-to-back.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // holds ~b in subtract mode
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;

    // Current slice of the captured operands summed with the running carry.
    always_comb begin
        a_slice   = a_q[cnt_q*CHUNK +: CHUNK];
        b_slice   = b_q[cnt_q*CHUNK +: CHUNK];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state logic: capture in IDLE, one slice per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    // Subtraction is A + ~B + 1, so the +1 rides in as the carry.
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[cnt_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                carry_d = slice_sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = slice_sum[CHUNK];
                    // Signed overflow: like-signed operands yielding a result of the other sign.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from state and result registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        s         = s_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Purpose: scoreboard bench for serial_chunk_adder (directed 8/2 instance plus 16-bit sweeps at CHUNK 1, 4, 16).
// Latency: expectations carry their accept edge so the monitor can check RUN length equals N.
// Backpressure: sweep instances get random out_ready stalls; the directed instance holds DONE for 10 cycles.
module tb_serial_chunk_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    logic clk;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic ci, input logic sb);
        exp_t   e;
        longint mask, half, ua, ub, c, sum, sa, sbv, ss;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & mask;
        ub   = sb ? (~longint'(bv) & mask) : (longint'(bv) & mask);
        c    = sb ? 1 : longint'(ci);
        sum  = ua + ub + c;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sbv  = (ub >= half) ? ub - (mask + 1) : ub;
        ss   = sa + sbv + c;
        e.s   = 16'(sum & mask);
        e.c   = ((sum >> w) & 1) != 0;
        e.o   = (ss > half - 1) || (ss < -half);
        e.acc = 0;
        return e;
    endfunction

    // ---------------- directed instance: WIDTH=8, CHUNK=2 ----------------
    logic       rst0 = 1'b1;
    logic       in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1;
    logic [7:0] a0 = '0, b0 = '0, s0;
    logic       cin0 = 1'b0, sub0 = 1'b0, cout0, ovf0;
    exp_t       q0[$];
    logic       ov_prev0 = 1'b0;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .s(s0), .cout(cout0), .ovf(ovf0)
    );

    always @(negedge clk) begin
        if (rst0) begin
            q0.delete();
            ov_prev0 = 1'b0;
        end else begin
            if (out_valid0 && !ov_prev0) begin
                if (q0.size() == 0) chk("d8 unexpected_out_valid", 1, 0);
                else chk("d8 latency", cyc - q0[0].acc, 4);
            end
            if (out_valid0 && out_ready0 && q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("d8 s", s0, e.s[7:0]);
                chk("d8 cout", cout0, e.c);
                chk("d8 ovf", ovf0, e.o);
            end
            ov_prev0 = out_valid0;
        end
    end

    task automatic send0(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                         input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        int   t;
        a0 = av; b0 = bv; cin0 = ci; sub0 = sb; in_valid0 = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready0) begin
            n_checks++; n_errors++;
            $display("FAIL d8 accept_timeout: in_ready %0d, required 1", in_ready0);
        end else begin
            e.s = {8'h00, es}; e.c = ec; e.o = eo; e.acc = cyc + 1;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom); sub0 = 1'($urandom);
    endtask

    task automatic drain0();
        int t;
        t = 0;
        while (q0.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q0.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL d8 drain_timeout: %0d results pending, required 0", q0.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- sweep instances: WIDTH=16, CHUNK = 1, 4, 16 ----------------
    logic rst_s = 1'b1;

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int C = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        localparam int N = 16 / C;

        logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
        logic [15:0] a = '0, b = '0, s;
        logic        cin = 1'b0, sub = 1'b0, cout, ovf;
        exp_t        q[$];
        logic        ov_prev = 1'b0;

        serial_chunk_adder #(.WIDTH(16), .CHUNK(C)) dut (
            .clk(clk), .rst(rst_s), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(out_valid), .out_ready(out_ready),
            .s(s), .cout(cout), .ovf(ovf)
        );

        initial begin
            forever begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end

        always @(negedge clk) begin
            if (!rst_s) begin
                if (out_valid && !ov_prev) begin
                    if (q.size() == 0) chk($sformatf("c%0d unexpected_out_valid", C), 1, 0);
                    else chk($sformatf("c%0d run_length", C), cyc - q[0].acc, N);
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("c%0d s", C), s, e.s);
                    chk($sformatf("c%0d cout", C), cout, e.c);
                    chk($sformatf("c%0d ovf", C), ovf, e.o);
                end
                ov_prev = out_valid;
            end
        end

        initial begin
            exp_t e;
            int   t;
            wait (rst_s == 1'b0);
            @(posedge clk);
            #1;
            for (int i = 0; i < 334; i++) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
                t = 0;
                @(negedge clk);
                while (!in_ready && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (!in_ready) begin
                    n_checks++; n_errors++;
                    $display("FAIL c%0d accept_timeout: in_ready %0d, required 1", C, in_ready);
                end else begin
                    e = model(16, a, b, cin, sub);
                    e.acc = cyc + 1;
                    q.push_back(e);
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                a = 16'($urandom); b = 16'($urandom);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            t = 0;
            while (q.size() != 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (q.size() != 0) begin
                n_checks++; n_errors++;
                $display("FAIL c%0d drain_timeout: %0d results pending, required 0", C, q.size());
            end
            n_done++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready0, 1);
        chk("reset out_valid", out_valid0, 0);
        chk("reset s", s0, 0);
        chk("reset cout", cout0, 0);
        chk("reset ovf", ovf0, 0);
        rst0  = 1'b0;
        rst_s = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, out_ready tied high.
        send0(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); drain0();
        send0(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); drain0();
        send0(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0); drain0();
        send0(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0); drain0();
        send0(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1); drain0();

        // Backpressure: hold DONE for 10 cycles while inputs wiggle.
        out_ready0 = 1'b0;
        send0(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
        t = 0;
        while (!out_valid0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid0) begin
            n_checks++; n_errors++;
            $display("FAIL d8 done_timeout: out_valid %0d, required 1", out_valid0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall s", s0, 8'h47);
            chk("stall cout", cout0, 0);
            chk("stall ovf", ovf0, 0);
            chk("stall in_ready", in_ready0, 0);
            chk("stall out_valid", out_valid0, 1);
            @(posedge clk);
            #1;
            a0 = 8'($urandom); b0 = 8'($urandom); in_valid0 = ~in_valid0;
        end
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        chk("release out_valid", out_valid0, 0);
        chk("release in_ready", in_ready0, 1);
        drain0();

        // Reset on the second RUN cycle aborts the operation.
        send0(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        #1;
        chk("abort out_valid", out_valid0, 0);
        chk("abort in_ready", in_ready0, 1);
        chk("abort s", s0, 0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        @(posedge clk);
        #1;
        send0(8'h55, 8'h0F, 1'b0, 1'b1, 8'h46, 1'b1, 1'b0); drain0();

        t = 0;
        while (n_done < 3 && t < 40000) begin
            @(posedge clk);
            t++;
        end
        if (n_done < 3) begin
            n_checks++; n_errors++;
            $display("FAIL sweep_timeout: %0d sweeps done, required 3", n_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
